// File: rtl/fmul_seq.sv
// Multi-cycle IEEE-754 binary32 multiplier: radix-4 Booth significand array
// (2 multiplier bits per cycle, 12 iterations) followed by one normalize/round cycle.
module fmul_seq #(
    parameter bit SPECIAL_FAST = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        valid,
    output logic [31:0] rslt,
    output logic [4:0]  flag
);

    localparam logic [3:0] CNT_IDLE   = 4'd0;
    localparam logic [3:0] CNT_FIRST  = 4'd1;
    localparam logic [3:0] CNT_FINISH = 4'd13;

    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_valid;
    logic [31:0] r_rslt;
    logic [4:0]  r_flag;
    logic        r_sign;
    logic [9:0]  r_exp;
    logic [23:0] r_frx;
    logic [25:0] r_mplr;
    logic        r_mprev;
    logic [49:0] r_acc;
    logic        r_spec;
    logic [31:0] r_spec_rslt;
    logic [4:0]  r_spec_flag;

    logic        w_sign;
    logic        w_xnan;
    logic        w_ynan;
    logic        w_xsnan;
    logic        w_ysnan;
    logic        w_xinf;
    logic        w_yinf;
    logic        w_xzero;
    logic        w_yzero;
    logic        w_spec;
    logic [31:0] w_spec_rslt;
    logic [4:0]  w_spec_flag;

    logic [25:0] w_xe;
    logic [25:0] w_pp;
    logic [49:0] w_sum;

    logic [47:0] w_p;
    logic [22:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_rnd;
    logic [23:0] w_mrnd;
    logic [9:0]  w_fexp;
    logic        w_uflow;
    logic        w_oflow;
    logic [31:0] w_rslt;
    logic [4:0]  w_flag;
    logic        w_finish;

    assign w_sign  = x[31] ^ y[31];
    assign w_xnan  = (x[30:23] == 8'hff) && (x[22:0] != 23'h0);
    assign w_ynan  = (y[30:23] == 8'hff) && (y[22:0] != 23'h0);
    assign w_xsnan = w_xnan && !x[22];
    assign w_ysnan = w_ynan && !y[22];
    assign w_xinf  = (x[30:23] == 8'hff) && (x[22:0] == 23'h0);
    assign w_yinf  = (y[30:23] == 8'hff) && (y[22:0] == 23'h0);
    // Denormals are flushed: any zero exponent counts as a zero operand.
    assign w_xzero = (x[30:23] == 8'h00);
    assign w_yzero = (y[30:23] == 8'h00);

    always_comb begin
        w_spec      = 1'b1;
        w_spec_rslt = 32'h0;
        w_spec_flag = 5'h00;
        if (w_xnan) begin
            w_spec_rslt = x | 32'h0040_0000;
            w_spec_flag = {w_xsnan | w_ysnan, 4'h0};
        end else if (w_ynan) begin
            w_spec_rslt = y | 32'h0040_0000;
            w_spec_flag = {w_ysnan, 4'h0};
        end else if ((w_xinf && w_yzero) || (w_xzero && w_yinf)) begin
            w_spec_rslt = 32'hffc0_0000;
            w_spec_flag = 5'h10;
        end else if (w_xinf || w_yinf) begin
            w_spec_rslt = {w_sign, 31'h7f80_0000};
        end else if (w_xzero || w_yzero) begin
            w_spec_rslt = {w_sign, 31'h0};
        end else begin
            w_spec = 1'b0;
        end
    end

    assign w_xe = {2'b00, r_frx};

    always_comb begin
        w_pp = 26'h0;
        case ({r_mplr[1:0], r_mprev})
            3'b001, 3'b010: w_pp = w_xe;
            3'b011:         w_pp = w_xe << 1;
            3'b100:         w_pp = -(w_xe << 1);
            3'b101, 3'b110: w_pp = -w_xe;
            default:        w_pp = 26'h0;
        endcase
    end

    assign w_sum = r_acc + {w_pp, 24'h0};

    // Twelve Booth digits leave the top multiplier bit pending as a final +1 digit;
    // it sits in r_mprev after the last shift and is folded in here.
    assign w_p = r_acc[47:0] + (r_mprev ? {r_frx, 24'h0} : 48'h0);

    always_comb begin
        if (w_p[47]) begin
            w_mant   = w_p[46:24];
            w_guard  = w_p[23];
            w_sticky = |w_p[22:0];
        end else begin
            w_mant   = w_p[45:23];
            w_guard  = w_p[22];
            w_sticky = |w_p[21:0];
        end
    end

    assign w_rnd   = w_guard & (w_sticky | w_mant[0]);
    assign w_mrnd  = {1'b0, w_mant} + {23'h0, w_rnd};
    assign w_fexp  = r_exp + {9'h0, w_p[47]} + {9'h0, w_mrnd[23]};
    assign w_uflow = w_fexp[9] || (w_fexp == 10'h0);
    assign w_oflow = !w_fexp[9] && (w_fexp >= 10'd255);

    always_comb begin
        w_rslt = {r_sign, w_fexp[7:0], w_mrnd[22:0]};
        w_flag = {4'h0, w_guard | w_sticky};
        if (r_spec) begin
            w_rslt = r_spec_rslt;
            w_flag = r_spec_flag;
        end else if (w_uflow) begin
            w_rslt = {r_sign, 31'h0};
            w_flag = 5'h03;
        end else if (w_oflow) begin
            w_rslt = {r_sign, 31'h7f80_0000};
            w_flag = 5'h05;
        end
    end

    assign w_finish = (r_cnt == CNT_FINISH) ||
                      (SPECIAL_FAST && (r_cnt == CNT_FIRST) && r_spec);

    // Control and datapath share one block: cnt 0 idle, 1..12 Booth steps, finish last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= CNT_IDLE;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_rslt      <= 32'h0;
            r_flag      <= 5'h00;
            r_sign      <= 1'b0;
            r_exp       <= 10'h0;
            r_frx       <= 24'h0;
            r_mplr      <= 26'h0;
            r_mprev     <= 1'b0;
            r_acc       <= 50'h0;
            r_spec      <= 1'b0;
            r_spec_rslt <= 32'h0;
            r_spec_flag <= 5'h00;
        end else begin
            r_valid <= 1'b0;
            if (r_cnt == CNT_IDLE) begin
                if (req) begin
                    r_sign      <= w_sign;
                    r_exp       <= {2'b00, x[30:23]} + {2'b00, y[30:23]} - 10'd127;
                    r_frx       <= {1'b1, x[22:0]};
                    r_mplr      <= {3'b001, y[22:0]};
                    r_mprev     <= 1'b0;
                    r_acc       <= 50'h0;
                    r_spec      <= w_spec;
                    r_spec_rslt <= w_spec_rslt;
                    r_spec_flag <= w_spec_flag;
                    r_busy      <= 1'b1;
                    r_cnt       <= CNT_FIRST;
                end
            end else if (w_finish) begin
                r_rslt  <= w_rslt;
                r_flag  <= w_flag;
                r_valid <= 1'b1;
                r_busy  <= 1'b0;
                r_cnt   <= CNT_IDLE;
            end else begin
                r_acc   <= {{2{w_sum[49]}}, w_sum[49:2]};
                r_mplr  <= {2'b00, r_mplr[25:2]};
                r_mprev <= r_mplr[1];
                r_cnt   <= r_cnt + 4'd1;
            end
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign rslt  = r_rslt;
    assign flag  = r_flag;

endmodule

// File: tb/tb_fmul_seq.sv
// Bench for fmul_seq: directed vectors plus random operands against an
// integer-arithmetic binary32 reference, on both SPECIAL_FAST settings.
module tb_fmul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0;
    logic        req1;
    logic [31:0] xIn;
    logic [31:0] yIn;
    logic        busy0;
    logic        valid0;
    logic [31:0] rslt0;
    logic [4:0]  flag0;
    logic        busy1;
    logic        valid1;
    logic [31:0] rslt1;
    logic [4:0]  flag1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fmul_seq #(.SPECIAL_FAST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .x(xIn), .y(yIn),
        .busy(busy0), .valid(valid0), .rslt(rslt0), .flag(flag0)
    );

    fmul_seq #(.SPECIAL_FAST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .x(xIn), .y(yIn),
        .busy(busy1), .valid(valid1), .rslt(rslt1), .flag(flag1)
    );

    localparam int NDIR = 7;
    logic [31:0] dirX [NDIR] = '{32'h3fc00000, 32'h3f800001, 32'h7f000000, 32'h00800000,
                                 32'h7f800000, 32'h7f800001, 32'hff800000};
    logic [31:0] dirY [NDIR] = '{32'h40000000, 32'h3f800001, 32'h40000000, 32'h00800000,
                                 32'h00000000, 32'h3f800000, 32'h3f800000};
    logic [31:0] dirR [NDIR] = '{32'h40400000, 32'h3f800002, 32'h7f800000, 32'h00000000,
                                 32'hffc00000, 32'h7fc00001, 32'hff800000};
    logic [4:0]  dirF [NDIR] = '{5'h00, 5'h01, 5'h05, 5'h03, 5'h10, 5'h10, 5'h00};
    bit          dirS [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Behavioural binary32 product: special rules first, then exact integer
    // product rounded to nearest-even by remainder comparison.
    task automatic refMul(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [4:0] f, output bit sp);
        int ea, eb, e, sh;
        longint unsigned ma, mb, p, q, rem, half;
        bit s, an, bn, asn, bsn, ai, bi, az, bz;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        an  = (ea == 255) && (a[22:0] != 0);
        bn  = (eb == 255) && (b[22:0] != 0);
        asn = an && !a[22];
        bsn = bn && !b[22];
        ai  = (ea == 255) && (a[22:0] == 0);
        bi  = (eb == 255) && (b[22:0] == 0);
        az  = (ea == 0);
        bz  = (eb == 0);
        s   = a[31] ^ b[31];
        sp  = 1'b1;
        f   = 5'h00;
        r   = 32'h0;
        if (an) begin
            r = a | 32'h00400000;
            f = (asn || bsn) ? 5'h10 : 5'h00;
        end else if (bn) begin
            r = b | 32'h00400000;
            f = bsn ? 5'h10 : 5'h00;
        end else if ((ai && bz) || (az && bi)) begin
            r = 32'hffc00000;
            f = 5'h10;
        end else if (ai || bi) begin
            r = {s, 31'h7f800000};
        end else if (az || bz) begin
            r = {s, 31'h0};
        end else begin
            sp   = 1'b0;
            ma   = 64'h800000 | 64'(a[22:0]);
            mb   = 64'h800000 | 64'(b[22:0]);
            p    = ma * mb;
            sh   = (p >= 64'h8000_0000_0000) ? 24 : 23;
            e    = ea + eb - 127 + (sh - 23);
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == 64'h1000000) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e <= 0) begin
                r = {s, 31'h0};
                f = 5'h03;
            end else if (e >= 255) begin
                r = {s, 31'h7f800000};
                f = 5'h05;
            end else begin
                r = {s, e[7:0], q[22:0]};
                f = (rem != 0) ? 5'h01 : 5'h00;
            end
        end
    endtask

    function automatic logic [31:0] randOperand();
        logic [31:0] v;
        int mode;
        v    = $urandom;
        mode = $urandom_range(0, 11);
        case (mode)
            0:       v = v;
            1:       v[30:23] = 8'h00;
            2:       v[30:23] = 8'hff;
            3:       v[30:0] = 31'h7f800000;
            4:       v[30:23] = 8'($urandom_range(190, 254));
            5:       v[30:23] = 8'($urandom_range(1, 60));
            6:       v[22:0] = 23'h7fffff;
            default: v[30:23] = 8'($urandom_range(90, 165));
        endcase
        return v;
    endfunction

    task automatic applyStimulus(input int which, input logic [31:0] a, input logic [31:0] b);
        xIn = a;
        yIn = b;
        if (which == 0) req0 = 1'b1;
        else            req1 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic waitValid(input int which, input int budget, output int lat, output int busyCnt);
        lat     = -1;
        busyCnt = 0;
        for (int k = 1; k <= budget; k++) begin
            if ((which == 0 ? busy0 : busy1) === 1'b1) busyCnt++;
            if ((which == 0 ? valid0 : valid1) === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic runOp(input int which, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expR, input logic [4:0] expF,
                         input int expLat, input int expBusy, input string tag);
        int lat, busyCnt;
        applyStimulus(which, a, b);
        waitValid(which, 40, lat, busyCnt);
        checkOutput({tag, " latency"}, lat, expLat);
        checkOutput({tag, " busy cycles"}, busyCnt, expBusy);
        checkOutput({tag, " rslt"}, (which == 0) ? rslt0 : rslt1, expR);
        checkOutput({tag, " flag"}, {27'h0, (which == 0) ? flag0 : flag1}, {27'h0, expF});
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] a, b, er, firstR;
        logic [4:0]  ef;
        bit          sp;
        int          which, lat, validSeen;

        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        xIn   = 32'h0;
        yIn   = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset rslt0", rslt0, 32'h0);
        checkOutput("reset ctl0", {25'h0, busy0, valid0, flag0}, 32'h0);
        checkOutput("reset rslt1", rslt1, 32'h0);
        checkOutput("reset ctl1", {25'h0, busy1, valid1, flag1}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NDIR; i++) begin
            runOp(0, dirX[i], dirY[i], dirR[i], dirF[i], 14, 13, $sformatf("dir0_%0d", i));
        end
        for (int i = 0; i < NDIR; i++) begin
            runOp(1, dirX[i], dirY[i], dirR[i], dirF[i], dirS[i] ? 2 : 14, dirS[i] ? 1 : 13,
                  $sformatf("dir1_%0d", i));
        end

        for (int i = 0; i < 48; i++) begin
            which = i % 2;
            a = randOperand();
            b = randOperand();
            refMul(a, b, er, ef, sp);
            runOp(which, a, b, er, ef, (which == 1 && sp) ? 2 : 14, (which == 1 && sp) ? 1 : 13,
                  $sformatf("rand%0d_%h_%h", i, a, b));
        end

        @(negedge clk);
        applyStimulus(0, 32'h3f800001, 32'h3f800001);
        validSeen = 0;
        lat       = -1;
        firstR    = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 4) begin
                xIn  = 32'h40000000;
                yIn  = 32'h40000000;
                req0 = 1'b1;
            end
            if (k == 5) req0 = 1'b0;
            if (valid0 === 1'b1) begin
                validSeen++;
                if (lat < 0) begin
                    lat    = k;
                    firstR = rslt0;
                end
            end
            @(negedge clk);
        end
        checkOutput("busy req ignored count", validSeen, 1);
        checkOutput("busy req ignored latency", lat, 14);
        checkOutput("busy req ignored rslt", firstR, 32'h3f800002);

        runOp(0, 32'h3fc00000, 32'h40000000, 32'h40400000, 5'h00, 14, 13, "b2b first");
        runOp(0, 32'h3f800001, 32'h3f800001, 32'h3f800002, 5'h01, 14, 13, "b2b second");

        @(negedge clk);
        applyStimulus(0, 32'h40400000, 32'h40400000);
        validSeen = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 7) reset = 1'b0;
            if (k == 9) reset = 1'b1;
            if (valid0 === 1'b1) validSeen++;
            @(negedge clk);
        end
        checkOutput("midop reset valid count", validSeen, 0);
        checkOutput("midop reset busy", {31'h0, busy0}, 32'h0);
        checkOutput("midop reset rslt", rslt0, 32'h0);
        runOp(0, 32'h40400000, 32'h40400000, 32'h41100000, 5'h00, 14, 13, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
